// File: rtl/t03_ssd_pkg.sv
// ---------------------------------------------------------------------------
// t03_ssd_pkg
// Shared types and default constants for the seven-segment scan driver.
//   nibble_t         : one hex digit as presented to the segment decoder
//   SSD_NDIGITS      : default number of scanned digits
//   SSD_REFRESH_DIV  : default clock cycles each digit stays selected
// ---------------------------------------------------------------------------
package t03_ssd_pkg;

    typedef logic [3:0] nibble_t;

    localparam int SSD_NDIGITS     = 4;
    localparam int SSD_REFRESH_DIV = 1000;

endpackage : t03_ssd_pkg

// File: rtl/t03_ssd_refresh_tick.sv
// ---------------------------------------------------------------------------
// t03_ssd_refresh_tick
// Modulo-N free-running counter. tick is high for the one cycle in which
// the count sits at N-1; the count then wraps to 0.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the count
//   tick : high while the count equals N-1
// ---------------------------------------------------------------------------
module t03_ssd_refresh_tick #(
    parameter int N = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0] rcnt_q;
    logic [CNT_W-1:0] rcnt_d;

    // Wrap by explicit compare so non-power-of-two N counts correctly.
    always_comb begin
        tick   = (rcnt_q == CNT_LAST);
        rcnt_d = tick ? '0 : rcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end

endmodule : t03_ssd_refresh_tick

// File: rtl/t03_ssd_scanner.sv
// ---------------------------------------------------------------------------
// t03_ssd_scanner
// Time-multiplexed scan driver for an NDIGITS seven-segment display. Each
// refresh slot selects one digit, presents its nibble and an enable to the
// downstream hex-to-segment decoder. New values arrive via load and are
// committed only at frame boundaries (last slot of the last digit), so a
// frame never mixes old and new digits.
// Ports:
//   clk          : system clock
//   rst          : synchronous active-high reset
//   data_in      : value to display, nibble i -> digit i (digit 0 = LSD)
//   load         : single-cycle request to display data_in
//   load_ack     : one-cycle pulse, coincident with the newly committed value
//   blank_lz     : leading-zero blanking enable
//   digit_sel    : one-hot active-high digit select
//   digit_nibble : nibble of the selected digit
//   digit_en     : decoder enable, 0 blanks the selected digit
// ---------------------------------------------------------------------------
module t03_ssd_scanner
    import t03_ssd_pkg::*;
#(
    parameter int NDIGITS     = SSD_NDIGITS,
    parameter int REFRESH_DIV = SSD_REFRESH_DIV
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NDIGITS-1:0]   data_in,
    input  logic                   load,
    output logic                   load_ack,
    input  logic                   blank_lz,
    output logic [NDIGITS-1:0]     digit_sel,
    output logic [3:0]             digit_nibble,
    output logic                   digit_en
);

    localparam int IDX_W = $clog2(NDIGITS);
    localparam int DW    = 4 * NDIGITS;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);

    logic             tick;
    logic             boundary;

    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [DW-1:0]    disp_q,     disp_d;
    logic [DW-1:0]    shadow_q,   shadow_d;
    logic             pending_q,  pending_d;
    logic             load_ack_q, load_ack_d;
    logic             blank_q,    blank_d;

    t03_ssd_refresh_tick #(
        .N (REFRESH_DIV)
    ) u_refresh_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign boundary = tick && (idx_q == IDX_LAST);

    always_comb begin
        idx_d      = idx_q;
        disp_d     = disp_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        load_ack_d = 1'b0;
        // blank_lz is registered so every output derives from flops only.
        blank_d    = blank_lz;

        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        // Later loads overwrite the shadow; all merge into one ack.
        if (load) begin
            shadow_d  = data_in;
            pending_d = 1'b1;
        end

        // A load in the boundary cycle bypasses the shadow and commits
        // directly, leaving pending clear.
        if (boundary && (pending_q || load)) begin
            disp_d     = load ? data_in : shadow_q;
            pending_d  = 1'b0;
            load_ack_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            disp_q     <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            load_ack_q <= 1'b0;
            blank_q    <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            load_ack_q <= load_ack_d;
            blank_q    <= blank_d;
        end
    end

    // Per-digit view of the display register and a nonzero flag per digit.
    nibble_t            disp_nib [NDIGITS];
    logic [NDIGITS-1:0] nib_nz;

    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_nib
        assign disp_nib[gi] = disp_q[4*gi +: 4];
        assign nib_nz[gi]   = |disp_q[4*gi +: 4];
    end

    logic [NDIGITS-1:0] upper_nz;

    always_comb begin
        digit_sel        = '0;
        digit_sel[idx_q] = 1'b1;
        digit_nibble     = disp_nib[idx_q];
        // Digit idx is a leading zero when it and every more significant
        // digit are zero; digit 0 always stays lit.
        upper_nz         = nib_nz >> idx_q;
        digit_en         = !blank_q || (idx_q == '0) || (|upper_nz);
    end

    assign load_ack = load_ack_q;

endmodule : t03_ssd_scanner

// File: tb/tb_t03_ssd_scanner.sv
// ---------------------------------------------------------------------------
// tb_t03_ssd_scanner
// Directed bench for the scan driver with NDIGITS=4, REFRESH_DIV=4.
// Cycle k counts from reset release: digit (k/4)%4 is selected, cycles with
// k%16==15 are frame boundaries, and a load seen in cycle L is displayed
// (with load_ack) in cycle (L/16+1)*16.
// ---------------------------------------------------------------------------
module tb_t03_ssd_scanner;

    localparam int ND = 4;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   data_in;
    logic          load;
    logic          load_ack;
    logic          blank_lz;
    logic [3:0]    digit_sel;
    logic [3:0]    digit_nibble;
    logic          digit_en;

    t03_ssd_scanner #(
        .NDIGITS     (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .load         (load),
        .load_ack     (load_ack),
        .blank_lz     (blank_lz),
        .digit_sel    (digit_sel),
        .digit_nibble (digit_nibble),
        .digit_en     (digit_en)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          commit_cyc = -1;
    logic [15:0] exp_disp = 16'h0000;
    logic [15:0] next_disp = 16'h0000;
    logic        exp_blank = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        int   idx;
        logic e;
        idx = (cyc / RD) % ND;
        if (!exp_blank || idx == 0) begin
            e = 1'b1;
        end else begin
            e = 1'b0;
            for (int j = idx; j < ND; j++) begin
                if (exp_disp[4*j +: 4] != 4'h0) e = 1'b1;
            end
        end
        chk("digit_sel",    {28'd0, digit_sel},    32'(4'b0001 << idx));
        chk("digit_nibble", {28'd0, digit_nibble}, {28'd0, exp_disp[4*idx +: 4]});
        chk("digit_en",     {31'd0, digit_en},     {31'd0, e});
        chk("load_ack",     {31'd0, load_ack},     {31'd0, (cyc == commit_cyc)});
    endtask

    // Advance one clock; blank_lz seen at this edge governs the next cycle.
    task automatic adv();
        logic b;
        b = blank_lz;
        step();
        cyc++;
        exp_blank = b;
        if (cyc == commit_cyc) exp_disp = next_disp;
        check_all();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) adv();
    endtask

    // Present a load in the current cycle; it is sampled at the next edge.
    task automatic do_load(input logic [15:0] v);
        data_in   = v;
        load      = 1'b1;
        next_disp = v;
        commit_cyc = (cyc / (ND * RD) + 1) * (ND * RD);
        $display("load %h in cyc %0d, commit due cyc %0d", v, cyc, commit_cyc);
        adv();
        load = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        data_in  = 16'h0000;
        load     = 1'b0;
        blank_lz = 1'b0;
        step();
        step();
        rst = 1'b0;
        cyc = 0;

        // 1: reset state and an idle frame
        check_all();
        chk("pending_rst", {31'd0, dut.pending_q}, 32'd0);
        run_to(15);

        // 2: load 12AF in cycle 2 of a frame, committed at the next frame
        run_to(18);
        do_load(16'h12AF);
        run_to(47);
        $display("frame shows %h", exp_disp);

        // 3: two loads in one frame merge; latest wins, single ack
        run_to(49);
        do_load(16'h1111);
        run_to(52);
        do_load(16'h2222);
        chk("pending_merge", {31'd0, dut.pending_q}, 32'd1);
        run_to(79);

        // 4: load exactly in the boundary cycle commits next cycle
        do_load(16'h0BEE);
        chk("pending_bypass", {31'd0, dut.pending_q}, 32'd0);
        adv();
        chk("pending_bypass2", {31'd0, dut.pending_q}, 32'd0);
        run_to(95);

        // 5: leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0005);
        run_to(111);
        do_load(16'h0000);
        run_to(127);
        do_load(16'h0050);
        run_to(143);
        blank_lz = 1'b0;
        run_to(159);

        // 6: reset mid-frame discards a pending load
        run_to(162);
        do_load(16'h9999);
        run_to(165);
        rst = 1'b1;
        step();
        chk("rst_sel",     {28'd0, digit_sel},    32'h1);
        chk("rst_nibble",  {28'd0, digit_nibble}, 32'h0);
        chk("rst_en",      {31'd0, digit_en},     32'h1);
        chk("rst_ack",     {31'd0, load_ack},     32'h0);
        chk("rst_pending", {31'd0, dut.pending_q}, 32'h0);
        rst        = 1'b0;
        cyc        = 0;
        commit_cyc = -1;
        exp_disp   = 16'h0000;
        exp_blank  = 1'b0;
        run_to(35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_t03_ssd_scanner

// File: doc/t03_ssd_scanner.md
# t03_ssd_scanner

Time-multiplexed scan driver for the team's multi-digit seven-segment display. It sits directly upstream of the per-digit hex-to-segment decoder. Each refresh slot it presents one 4-bit nibble and an enable to the decoder, and it drives a one-hot digit select to the board. New display values arrive through a load/ack handshake and are committed only at frame boundaries, so a digit never shows a mix of old and new values mid-frame.

## Interface
Parameters:
- `NDIGITS`, 4, number of digits scanned; legal range ≥ 2.
- `REFRESH_DIV`, 1000, clock cycles each digit stays selected; legal range ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous and active-high.
- `data_in`  in  4*NDIGITS  value to display; nibble i drives digit i, and digit 0 is the least significant.
- `load`  in  1  single-cycle request to display `data_in`.
- `load_ack`  out  1  one-cycle pulse: a requested value has been committed to the display.
- `blank_lz`  in  1  leading-zero blanking enable; sampled every cycle.
- `digit_sel`  out  NDIGITS  one-hot, active-high select of the digit currently driven.
- `digit_nibble`  out  4  nibble for the selected digit; connects to the decoder's `in`.
- `digit_en`  out  1  decoder enable; 0 blanks the selected digit.

## Operation
- Refresh counter `rcnt` counts 0..REFRESH_DIV-1 and wraps. A `tick` occurs in any cycle where `rcnt == REFRESH_DIV-1`.
- Digit index `idx` counts 0..NDIGITS-1 and advances on `tick`. After NDIGITS-1 it wraps to 0.
- Frame boundary: a `tick` while `idx == NDIGITS-1`.
- Shadow register:
  - When `load=1`, `shadow <= data_in` and `pending <= 1`.
  - A further load while `pending=1` overwrites `shadow`; the latest value wins. Only one `load_ack` is produced for the merged loads.
- Commit at a frame boundary when `pending=1` or `load=1`:
  - `disp <= (load ? data_in : shadow)`.
  - `pending <= 0`.
  - `load_ack` is 1 in the next cycle.
- With no pending request at a boundary, `disp` holds its value and `load_ack` stays 0.
- Output decode depends on registered state only; there is no combinational path from inputs to outputs:
  - `digit_sel = 1 << idx`.
  - `digit_nibble = disp[4*idx +: 4]`.
- `digit_en`:
  - 1 when `blank_lz=0`.
  - 1 when `idx==0`; digit 0 is never blanked.
  - Otherwise 0 if every nibble of `disp` from `idx` through NDIGITS-1 is 0, else 1.
- Reset mid-frame aborts the frame and discards any pending load. No `load_ack` is issued for a discarded load.

## Timing
- Reset values:
  - `rcnt=0`, `idx=0`, `disp=0`, `shadow=0`, `pending=0`.
  - `load_ack=0`, `digit_sel=1`, `digit_nibble=0`, `digit_en=1`.
- Each digit stays selected for exactly REFRESH_DIV cycles. A frame lasts NDIGITS*REFRESH_DIV cycles.
- `idx` changes in the cycle after `tick`, and the outputs reflect the new `idx` in that same cycle.
- Load-to-display latency:
  - Minimum 1 cycle, when the load arrives in the boundary cycle.
  - Maximum NDIGITS*REFRESH_DIV cycles.
- `load_ack` appears in the same cycle as the new `disp`.
- `load` and boundary in the same cycle: `data_in` is committed directly, and `pending` stays 0.
- Counter widths: `rcnt` is `$clog2(REFRESH_DIV)` bits; `idx` is `$clog2(NDIGITS)` bits. Wrap is by explicit compare, never by natural overflow, so non-power-of-2 values work.

## Structure
- Shared package `t03_ssd_pkg` holds:
  - `typedef logic [3:0] nibble_t`.
  - Default constants `SSD_NDIGITS=4` and `SSD_REFRESH_DIV=1000`.
- Sub-module `t03_ssd_refresh_tick`: parameterised modulo-N counter with `clk`, `rst` and a `tick` output. The scanner instantiates it once.
- The top level instantiates NDIGITS copies of the hex-to-segment decoder, one per digit, downstream of this block. They are not inside this block.

## Test plan
All scenarios use NDIGITS=4 and REFRESH_DIV=4 unless noted.
1. Reset, then run 16 cycles.
   - Required: `digit_sel` steps 0001→0010→0100→1000, 4 cycles each.
   - Required: `digit_nibble=0` and `digit_en=1` throughout.
   - Required: `load_ack` never asserts.
2. Load `data_in=16'h12AF` in cycle 2 of frame 0.
   - Required: `disp` unchanged until the boundary; `load_ack` pulses once in the cycle after the boundary.
   - Required: the next frame shows nibbles F, A, 2, 1 on digits 0..3.
3. Load `16'h1111`, then `16'h2222` three cycles later, in the same frame.
   - Required: a single `load_ack`; the display shows 2222.
4. Assert `load` with `16'h0BEE` exactly in the boundary cycle.
   - Required: `disp=0BEE` next cycle, `load_ack=1` in that same cycle, and `pending` stays 0.
5. Set `disp=16'h0005` and `blank_lz=1`.
   - Required: `digit_en` is 1 on digit 0 and 0 on digits 1–3.
   - Required: with `disp=16'h0000`, only digit 0 is enabled and shows 0.
   - Required: with `blank_lz=0`, all digits are enabled.
6. Load `16'h9999`, then assert `rst` mid-frame before the boundary.
   - Required: all outputs take their reset values next cycle.
   - Required: no `load_ack` is issued and `disp` stays 0 through the following frame.
